uart_boot_loader: RTL

- CPU-side end of the UART boot protocol. Sends sync byte 0x99, receives a 4-byte little-endian program size, then receives that many program bytes. Packs them into 32-bit little-endian words and writes them into instruction memory.
- When the program is loaded, sends ready byte 0xAA and asserts boot_done, which hands the UART and CPU execution to the core.
- Sits between the CPU's UART_RX/UART_TX byte interfaces and the instruction-memory write port.

---
 rtl/uart_boot_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// CPU-side UART boot loader: sends sync byte, takes a 4-byte LE size, packs program bytes into LE imem words, then sends ready byte.
// Write pulse lands the cycle after the completing rx strobe; tx_start only while tx_busy=0, followed by a one-cycle guard.
module uart_boot_loader #(
   parameter int unsigned IMEM_ADDR_WIDTH = 15,
   parameter logic [7:0]  SYNC_BYTE       = 8'h99,
   parameter logic [7:0]  READY_BYTE      = 8'hAA
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [7:0]                 rx_rdata,
   input  logic                       rx_rdata_ready,
   input  logic                       rx_ferr,
   output logic [7:0]                 tx_sdata,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic                       imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
   output logic [31:0]                imem_wdata,
   output logic [31:0]                program_size_byte,
   output logic                       boot_done,
   output logic                       size_error
);
   localparam logic [32:0] CAPACITY = 33'd4 << IMEM_ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_SEND_SYNC,
      S_RECV_SIZE,
      S_RECV_PROG,
      S_SEND_READY,
      S_DRAIN_READY,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                     state_q, state_d;
   logic                       guard_q;
   logic [1:0]                 size_cnt_q, size_cnt_d;
   logic [23:0]                size_asm_q, size_asm_d;
   logic [31:0]                size_q, size_d;
   logic [31:0]                byte_cnt_q, byte_cnt_d;
   logic [31:0]                word_q, word_d;
   logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [IMEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]                wdata_q, wdata_d;
   logic                       we_q, we_d;

   logic                       tx_go;
   logic [7:0]                 tx_byte;
   logic                       rx_ok, rx_bad;
   logic [31:0]                size_full;
   logic [31:0]                word_merged;
   logic                       last_byte;

   assign rx_ok       = rx_rdata_ready & ~rx_ferr;
   assign rx_bad      = rx_rdata_ready & rx_ferr;
   assign size_full   = {rx_rdata, size_asm_q};
   assign word_merged = word_q | ({24'd0, rx_rdata} << {byte_cnt_q[1:0], 3'b000});
   assign last_byte   = (byte_cnt_q + 32'd1) == size_q;

   always_comb begin
      state_d    = state_q;
      size_cnt_d = size_cnt_q;
      size_asm_d = size_asm_q;
      size_d     = size_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      addr_d     = addr_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      tx_go      = 1'b0;
      tx_byte    = 8'd0;

      case (state_q)
         S_SEND_SYNC: begin
            if (!tx_busy) begin
               tx_go      = 1'b1;
               tx_byte    = SYNC_BYTE;
               state_d    = S_RECV_SIZE;
               size_cnt_d = 2'd0;
               size_asm_d = 24'd0;
               byte_cnt_d = 32'd0;
               word_d     = 32'd0;
               addr_d     = '0;
            end
         end
         S_RECV_SIZE: begin
            if (rx_bad) begin
               state_d = S_ERROR;
            end else if (rx_ok) begin
               size_cnt_d = size_cnt_q + 2'd1;
               if (size_cnt_q == 2'd3) begin
                  size_d = size_full;
                  // Range check happens before any write, so the address can never wrap.
                  if ({1'b0, size_full} > CAPACITY) state_d = S_ERROR;
                  else if (size_full == 32'd0)      state_d = S_SEND_READY;
                  else                              state_d = S_RECV_PROG;
               end else begin
                  size_asm_d = size_asm_q | ({16'd0, rx_rdata} << {size_cnt_q, 3'b000});
               end
            end
         end
         S_RECV_PROG: begin
            if (rx_bad) begin
               state_d = S_ERROR;
            end else if (rx_ok) begin
               byte_cnt_d = byte_cnt_q + 32'd1;
               if (byte_cnt_q[1:0] == 2'd3 || last_byte) begin
                  we_d    = 1'b1;
                  wdata_d = word_merged;
                  waddr_d = addr_q;
                  addr_d  = addr_q + 1'b1;
                  word_d  = 32'd0;
                  if (last_byte) state_d = S_SEND_READY;
               end else begin
                  word_d = word_merged;
               end
            end
         end
         S_SEND_READY: begin
            if (!tx_busy && !guard_q) begin
               tx_go   = 1'b1;
               tx_byte = READY_BYTE;
               state_d = S_DRAIN_READY;
            end
         end
         S_DRAIN_READY: begin
            // Busy rises one cycle late, so the guard cycle's idle reading is not trusted.
            if (!guard_q && !tx_busy) state_d = S_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_SEND_SYNC;
         guard_q    <= 1'b0;
         size_cnt_q <= 2'd0;
         size_asm_q <= 24'd0;
         size_q     <= 32'd0;
         byte_cnt_q <= 32'd0;
         word_q     <= 32'd0;
         addr_q     <= '0;
         waddr_q    <= '0;
         wdata_q    <= 32'd0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         guard_q    <= tx_go;
         size_cnt_q <= size_cnt_d;
         size_asm_q <= size_asm_d;
         size_q     <= size_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
      end
   end

   // Gate the combinational TX request so nothing leaks out while reset is held.
   assign tx_start          = reset_n & tx_go;
   assign tx_sdata          = reset_n ? tx_byte : 8'd0;
   assign imem_we           = we_q;
   assign imem_waddr        = waddr_q;
   assign imem_wdata        = wdata_q;
   assign program_size_byte = size_q;
   assign boot_done         = (state_q == S_DONE);
   assign size_error        = (state_q == S_ERROR);

endmodule
